// File: rtl/clock_divider_multi_if.sv
// Control/status bundle for clock_divider_multi: run requests, divisor write port
// and per-channel divided-clock outputs.
interface clock_divider_multi_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DIV_BW = 16,
    parameter int unsigned CH_BW  = 2
);
    logic [N_CH-1:0]   ch_enable;
    logic              sync_restart;
    logic              wr_en;
    logic [CH_BW-1:0]  wr_ch;
    logic [DIV_BW-1:0] wr_div;
    logic              wr_err;
    logic [N_CH-1:0]   div_pending;
    logic [N_CH-1:0]   ch_running;
    logic [N_CH-1:0]   div_clk;
    logic [N_CH-1:0]   div_clk_pulse;

    modport master (
        output ch_enable, sync_restart, wr_en, wr_ch, wr_div,
        input  wr_err, div_pending, ch_running, div_clk, div_clk_pulse
    );

    modport slave (
        input  ch_enable, sync_restart, wr_en, wr_ch, wr_div,
        output wr_err, div_pending, ch_running, div_clk, div_clk_pulse
    );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider, fully synchronous to i_ref_clock.
// Each channel emits a registered divided clock and a first-cycle-of-period pulse.
module clock_divider_multi #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned DIV_BW    = 16,
    parameter int unsigned DIV_RESET = 2,
    parameter int unsigned CH_BW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 i_ref_clock,
    input  logic                 i_reset,
    clock_divider_multi_if.slave io_bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic            w_wr_ok;
    logic            r_wr_err;
    logic [N_CH-1:0] w_pending;
    logic [N_CH-1:0] w_running;
    logic [N_CH-1:0] w_div_clk;
    logic [N_CH-1:0] w_pulse;

    assign w_wr_ok = io_bus.wr_en && (io_bus.wr_div != '0) && (32'(io_bus.wr_ch) < N_CH);

    always_ff @(posedge i_ref_clock) begin
        if (i_reset) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= io_bus.wr_en && !w_wr_ok;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [1:0]        r_state, w_state_nxt;
        logic              r_start, w_start_nxt;
        logic [DIV_BW-1:0] r_cnt, w_cnt_nxt;
        logic [DIV_BW-1:0] r_act, w_act_nxt;
        logic [DIV_BW-1:0] r_shd, w_shd_nxt;
        logic              r_pend, w_pend_nxt;
        logic              r_clk, w_clk_nxt;
        logic              r_pulse, w_pulse_nxt;
        logic              w_wr;
        logic              w_wrap;
        logic              w_go_idle;
        logic [DIV_BW-1:0] w_boundary_div;
        logic [DIV_BW:0]   w_cnt_inc;
        logic [DIV_BW:0]   w_half;

        assign w_wr           = w_wr_ok && (io_bus.wr_ch == CH_BW'(c));
        assign w_wrap         = (r_cnt == (r_act - DIV_BW'(1)));
        assign w_boundary_div = r_pend ? r_shd : r_act;
        assign w_cnt_inc      = {1'b0, r_cnt} + (DIV_BW+1)'(1);
        assign w_half         = ({1'b0, r_act} + (DIV_BW+1)'(1)) >> 1;

        // Leave the counter when a drain is cut short by a restart, or when the
        // period ends with no run request (r_start marks a period not yet begun).
        assign w_go_idle = (r_state != StIdle) &&
                           ((io_bus.sync_restart && (r_state == StDrain)) ||
                            (w_wrap && !r_start && !io_bus.sync_restart &&
                             !io_bus.ch_enable[c]));

        always_comb begin
            w_state_nxt = r_state;
            w_start_nxt = r_start;
            w_cnt_nxt   = r_cnt;
            w_act_nxt   = r_act;
            w_shd_nxt   = r_shd;
            w_pend_nxt  = r_pend;
            w_clk_nxt   = r_clk;
            w_pulse_nxt = r_pulse;

            if ((r_state == StIdle) || w_go_idle) begin
                w_state_nxt = StIdle;
                w_start_nxt = 1'b0;
                w_cnt_nxt   = '0;
                w_act_nxt   = w_boundary_div;
                w_pend_nxt  = 1'b0;
                w_clk_nxt   = 1'b0;
                w_pulse_nxt = 1'b0;
                if ((r_state == StIdle) && io_bus.ch_enable[c]) begin
                    w_state_nxt = StRun;
                    // A start coinciding with a restart joins the others in phase.
                    if (io_bus.sync_restart) begin
                        w_clk_nxt   = 1'b1;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_start_nxt = 1'b1;
                    end
                end
            end else begin
                w_state_nxt = io_bus.ch_enable[c] ? StRun : StDrain;
                w_start_nxt = 1'b0;
                if (io_bus.sync_restart || r_start || w_wrap) begin
                    w_cnt_nxt   = '0;
                    w_act_nxt   = w_boundary_div;
                    w_pend_nxt  = 1'b0;
                    w_clk_nxt   = 1'b1;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc[DIV_BW-1:0];
                    w_clk_nxt   = (w_cnt_inc < w_half);
                    w_pulse_nxt = 1'b0;
                end
            end

            // A write landing on a boundary edge waits for the following boundary.
            if (w_wr) begin
                w_shd_nxt  = io_bus.wr_div;
                w_pend_nxt = 1'b1;
            end
        end

        always_ff @(posedge i_ref_clock) begin
            if (i_reset) begin
                r_state <= StIdle;
                r_start <= 1'b0;
                r_cnt   <= '0;
                r_act   <= DIV_BW'(DIV_RESET);
                r_shd   <= DIV_BW'(DIV_RESET);
                r_pend  <= 1'b0;
                r_clk   <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_start <= w_start_nxt;
                r_cnt   <= w_cnt_nxt;
                r_act   <= w_act_nxt;
                r_shd   <= w_shd_nxt;
                r_pend  <= w_pend_nxt;
                r_clk   <= w_clk_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        assign w_pending[c] = r_pend;
        assign w_running[c] = (r_state != StIdle);
        assign w_div_clk[c] = r_clk;
        assign w_pulse[c]   = r_pulse;
    end

    assign io_bus.wr_err        = r_wr_err;
    assign io_bus.div_pending   = w_pending;
    assign io_bus.ch_running    = w_running;
    assign io_bus.div_clk       = w_div_clk;
    assign io_bus.div_clk_pulse = w_pulse;
endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed self-checking bench for clock_divider_multi.
// CH_BW is widened to 3 so that an out-of-range wr_ch (== N_CH) is expressible.
module tb_clock_divider_multi;
    localparam int unsigned N_CH   = 4;
    localparam int unsigned DIV_BW = 16;
    localparam int unsigned CH_BW  = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    clock_divider_multi_if #(.N_CH(N_CH), .DIV_BW(DIV_BW), .CH_BW(CH_BW)) bif ();

    clock_divider_multi #(
        .N_CH      (N_CH),
        .DIV_BW    (DIV_BW),
        .DIV_RESET (2),
        .CH_BW     (CH_BW)
    ) dut (
        .i_ref_clock (clk),
        .i_reset     (rst),
        .io_bus      (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bif.ch_enable    = '0;
        bif.sync_restart = 1'b0;
        bif.wr_en        = 1'b0;
        bif.wr_ch        = '0;
        bif.wr_div       = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_div(input int ch, input int div);
        bif.wr_en  = 1'b1;
        bif.wr_ch  = CH_BW'(ch);
        bif.wr_div = DIV_BW'(div);
        tick();
        bif.wr_en  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({bif.div_clk, bif.div_clk_pulse, bif.ch_running, bif.div_pending} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {bif.div_clk, bif.div_clk_pulse, bif.ch_running, bif.div_pending});
        end
        n_tests++;
        if (bif.wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr_err: got %b expected 0", bif.wr_err);
        end
    endtask

    task automatic test_d2();
        do_reset();
        bif.ch_enable[0] = 1'b1;
        tick();
        n_tests++;
        if ({bif.ch_running[0], bif.div_clk[0], bif.div_clk_pulse[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL d2_start_latency: got %b expected 100",
                     {bif.ch_running[0], bif.div_clk[0], bif.div_clk_pulse[0]});
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if ({bif.div_clk[0], bif.div_clk_pulse[0]} !== {2{(i % 2) == 0}}) begin
                n_fail++;
                $display("FAIL d2_pattern[%0d]: got %b expected %b", i,
                         {bif.div_clk[0], bif.div_clk_pulse[0]}, {2{(i % 2) == 0}});
            end
            tick();
        end
    endtask

    task automatic test_d5_d1();
        do_reset();
        write_div(1, 5);
        n_tests++;
        if (bif.div_pending !== 4'b0010) begin
            n_fail++;
            $display("FAIL d5_pending_set: got %b expected 0010", bif.div_pending);
        end
        tick();
        n_tests++;
        if (bif.div_pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL d5_pending_idle_apply: got %b expected 0000", bif.div_pending);
        end
        bif.ch_enable[1] = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if ({bif.div_clk[1], bif.div_clk_pulse[1]} !== {(i % 5) < 3, (i % 5) == 0}) begin
                n_fail++;
                $display("FAIL d5_pattern[%0d]: got %b expected %b", i,
                         {bif.div_clk[1], bif.div_clk_pulse[1]}, {(i % 5) < 3, (i % 5) == 0});
            end
            tick();
        end
        do_reset();
        write_div(1, 1);
        tick();
        bif.ch_enable[1] = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({bif.div_clk[1], bif.div_clk_pulse[1]} !== 2'b11) begin
                n_fail++;
                $display("FAIL d1_pattern[%0d]: got %b expected 11", i,
                         {bif.div_clk[1], bif.div_clk_pulse[1]});
            end
            tick();
        end
    endtask

    task automatic test_update();
        logic [2:0] exp_pend;
        logic [2:0] exp_clk;
        logic [2:0] exp_pulse;
        exp_pend  = 3'b011;
        exp_clk   = 3'b100;
        exp_pulse = 3'b100;
        do_reset();
        write_div(2, 4);
        tick();
        bif.ch_enable[2] = 1'b1;
        tick();
        tick();
        tick();
        n_tests++;
        if ({bif.div_clk[2], bif.div_clk_pulse[2]} !== 2'b10) begin
            n_fail++;
            $display("FAIL upd_cnt1: got %b expected 10", {bif.div_clk[2], bif.div_clk_pulse[2]});
        end
        write_div(2, 6);
        for (int j = 0; j < 3; j++) begin
            n_tests++;
            if ({bif.div_pending[2], bif.div_clk[2], bif.div_clk_pulse[2]} !==
                {exp_pend[j], exp_clk[j], exp_pulse[j]}) begin
                n_fail++;
                $display("FAIL upd_boundary[%0d]: got %b expected %b", j,
                         {bif.div_pending[2], bif.div_clk[2], bif.div_clk_pulse[2]},
                         {exp_pend[j], exp_clk[j], exp_pulse[j]});
            end
            if (j < 2) tick();
        end
        for (int i = 1; i < 12; i++) begin
            tick();
            n_tests++;
            if ({bif.div_clk[2], bif.div_clk_pulse[2]} !== {(i % 6) < 3, (i % 6) == 0}) begin
                n_fail++;
                $display("FAIL upd_d6[%0d]: got %b expected %b", i,
                         {bif.div_clk[2], bif.div_clk_pulse[2]}, {(i % 6) < 3, (i % 6) == 0});
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_div(0, 8);
        tick();
        bif.ch_enable[0] = 1'b1;
        tick();
        tick();
        write_div(0, 3);
        write_div(0, 5);
        for (int c = 3; c < 8; c++) begin
            tick();
            n_tests++;
            if ({bif.div_pending[0], bif.div_clk_pulse[0]} !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_hold[%0d]: got %b expected 10", c,
                         {bif.div_pending[0], bif.div_clk_pulse[0]});
            end
        end
        tick();
        n_tests++;
        if ({bif.div_pending[0], bif.div_clk_pulse[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_apply: got %b expected 01", {bif.div_pending[0], bif.div_clk_pulse[0]});
        end
        for (int i = 1; i < 5; i++) begin
            tick();
            n_tests++;
            if ({bif.div_clk[0], bif.div_clk_pulse[0]} !== {i < 3, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_last_wins[%0d]: got %b expected %b", i,
                         {bif.div_clk[0], bif.div_clk_pulse[0]}, {i < 3, 1'b0});
            end
        end
        write_div(0, 2);
        n_tests++;
        if ({bif.div_pending[0], bif.div_clk_pulse[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_wrap_write: got %b expected 11", {bif.div_pending[0], bif.div_clk_pulse[0]});
        end
        for (int i = 1; i < 5; i++) begin
            tick();
            n_tests++;
            if ({bif.div_pending[0], bif.div_clk[0], bif.div_clk_pulse[0]} !== {1'b1, i < 3, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_deferred[%0d]: got %b expected %b", i,
                         {bif.div_pending[0], bif.div_clk[0], bif.div_clk_pulse[0]}, {1'b1, i < 3, 1'b0});
            end
        end
        tick();
        tick();
        n_tests++;
        if ({bif.div_pending[0], bif.div_clk[0], bif.div_clk_pulse[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_d2_low: got %b expected 000",
                     {bif.div_pending[0], bif.div_clk[0], bif.div_clk_pulse[0]});
        end
        tick();
        n_tests++;
        if ({bif.div_clk[0], bif.div_clk_pulse[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_d2_pulse: got %b expected 11", {bif.div_clk[0], bif.div_clk_pulse[0]});
        end
    endtask

    task automatic test_drain();
        do_reset();
        write_div(0, 8);
        tick();
        bif.ch_enable[0] = 1'b1;
        repeat (4) tick();
        bif.ch_enable[0] = 1'b0;
        for (int c = 3; c < 8; c++) begin
            tick();
            n_tests++;
            if ({bif.ch_running[0], bif.div_clk[0], bif.div_clk_pulse[0]} !== {1'b1, c < 4, 1'b0}) begin
                n_fail++;
                $display("FAIL drain_cnt%0d: got %b expected %b", c,
                         {bif.ch_running[0], bif.div_clk[0], bif.div_clk_pulse[0]}, {1'b1, c < 4, 1'b0});
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if ({bif.ch_running[0], bif.div_clk[0], bif.div_clk_pulse[0]} !== 3'b000) begin
                n_fail++;
                $display("FAIL drain_idle[%0d]: got %b expected 000", i,
                         {bif.ch_running[0], bif.div_clk[0], bif.div_clk_pulse[0]});
            end
        end
        do_reset();
        write_div(0, 8);
        tick();
        bif.ch_enable[0] = 1'b1;
        repeat (4) tick();
        bif.ch_enable[0] = 1'b0;
        repeat (3) tick();
        bif.ch_enable[0] = 1'b1;
        tick();
        n_tests++;
        if ({bif.ch_running[0], bif.div_clk[0], bif.div_clk_pulse[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL reenable_no_restart: got %b expected 100",
                     {bif.ch_running[0], bif.div_clk[0], bif.div_clk_pulse[0]});
        end
        tick();
        tick();
        n_tests++;
        if ({bif.div_clk[0], bif.div_clk_pulse[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL reenable_wrap: got %b expected 11", {bif.div_clk[0], bif.div_clk_pulse[0]});
        end
        tick();
        n_tests++;
        if ({bif.ch_running[0], bif.div_clk[0], bif.div_clk_pulse[0]} !== 3'b110) begin
            n_fail++;
            $display("FAIL reenable_continues: got %b expected 110",
                     {bif.ch_running[0], bif.div_clk[0], bif.div_clk_pulse[0]});
        end
    endtask

    task automatic test_sync();
        do_reset();
        write_div(0, 4);
        write_div(1, 6);
        tick();
        bif.ch_enable = 4'b0011;
        repeat (4) tick();
        n_tests++;
        if ({bif.div_clk[1:0], bif.div_clk_pulse[1:0]} !== 4'b1000) begin
            n_fail++;
            $display("FAIL sync_pre: got %b expected 1000", {bif.div_clk[1:0], bif.div_clk_pulse[1:0]});
        end
        bif.sync_restart = 1'b1;
        bif.ch_enable    = 4'b0111;
        tick();
        bif.sync_restart = 1'b0;
        n_tests++;
        if ({bif.div_clk_pulse, bif.div_clk, bif.ch_running} !== 12'h777) begin
            n_fail++;
            $display("FAIL sync_align: got %h expected 777",
                     {bif.div_clk_pulse, bif.div_clk, bif.ch_running});
        end
        tick();
        n_tests++;
        if ({bif.div_clk_pulse, bif.div_clk} !== 8'h03) begin
            n_fail++;
            $display("FAIL sync_after: got %h expected 03", {bif.div_clk_pulse, bif.div_clk});
        end
        bif.ch_enable = 4'b0101;
        tick();
        bif.sync_restart = 1'b1;
        tick();
        bif.sync_restart = 1'b0;
        n_tests++;
        if ({bif.ch_running, bif.div_clk_pulse, bif.div_clk} !== 12'h555) begin
            n_fail++;
            $display("FAIL sync_drain_idle: got %h expected 555",
                     {bif.ch_running, bif.div_clk_pulse, bif.div_clk});
        end
    endtask

    task automatic test_errors();
        do_reset();
        bif.wr_en  = 1'b1;
        bif.wr_ch  = 3'd0;
        bif.wr_div = '0;
        tick();
        bif.wr_en = 1'b0;
        n_tests++;
        if ({bif.wr_err, bif.div_pending} !== 5'b10000) begin
            n_fail++;
            $display("FAIL err_div0: got %b expected 10000", {bif.wr_err, bif.div_pending});
        end
        tick();
        n_tests++;
        if (bif.wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: got %b expected 0", bif.wr_err);
        end
        bif.wr_en  = 1'b1;
        bif.wr_ch  = 3'd4;
        bif.wr_div = 16'd5;
        tick();
        bif.wr_en = 1'b0;
        n_tests++;
        if ({bif.wr_err, bif.div_pending} !== 5'b10000) begin
            n_fail++;
            $display("FAIL err_bad_ch: got %b expected 10000", {bif.wr_err, bif.div_pending});
        end
        write_div(3, 9);
        n_tests++;
        if ({bif.wr_err, bif.div_pending} !== 5'b01000) begin
            n_fail++;
            $display("FAIL err_good_write: got %b expected 01000", {bif.wr_err, bif.div_pending});
        end
        bif.ch_enable[0] = 1'b1;
        tick();
        tick();
        tick();
        n_tests++;
        if ({bif.div_clk[0], bif.div_clk_pulse[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL err_ch0_unchanged: got %b expected 00", {bif.div_clk[0], bif.div_clk_pulse[0]});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_div(0, 5);
        tick();
        bif.ch_enable[0] = 1'b1;
        repeat (3) tick();
        rst        = 1'b1;
        bif.wr_en  = 1'b1;
        bif.wr_ch  = 3'd1;
        bif.wr_div = 16'd7;
        tick();
        rst       = 1'b0;
        bif.wr_en = 1'b0;
        n_tests++;
        if ({bif.wr_err, bif.div_clk, bif.div_clk_pulse, bif.ch_running, bif.div_pending} !== 17'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h expected 0",
                     {bif.wr_err, bif.div_clk, bif.div_clk_pulse, bif.ch_running, bif.div_pending});
        end
        tick();
        tick();
        n_tests++;
        if ({bif.div_clk[0], bif.div_clk_pulse[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_mid_restart: got %b expected 11", {bif.div_clk[0], bif.div_clk_pulse[0]});
        end
        tick();
        n_tests++;
        if ({bif.div_clk[0], bif.div_clk_pulse[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_div_reset: got %b expected 00", {bif.div_clk[0], bif.div_clk_pulse[0]});
        end
        tick();
        n_tests++;
        if ({bif.div_clk[0], bif.div_clk_pulse[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_mid_period2: got %b expected 11", {bif.div_clk[0], bif.div_clk_pulse[0]});
        end
    endtask

    initial begin
        test_reset();
        test_d2();
        test_d5_d1();
        test_update();
        test_back_to_back();
        test_drain();
        test_sync();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
